// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
// REG_DUMP_CHECKSUM_EN widens the state encoding to make room for the checksum beat state.
package reg_dump_pkg;

  localparam int unsigned REG_DUMP_ADDR_W = 5;
  localparam int unsigned REG_DUMP_DATA_W = 32;

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    HOLD = 3'd2,
    DONE = 3'd3,
    CSUM = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;
`endif

endpackage : reg_dump_pkg

// File: rtl/reg_dump_reader.sv
// Walks register-file addresses FIRST_REG..LAST_REG and streams (addr, data) beats out.
// Defining REG_DUMP_CHECKSUM_EN appends an XOR checksum beat (addr 0) after the last register.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned ADDR_W    = REG_DUMP_ADDR_W,
  parameter int unsigned DATA_W    = REG_DUMP_DATA_W,
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              at_last_c;
  logic              accept_c;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign at_last_c = (rf_addr_q == ADDR_W'(LAST_REG));
  assign accept_c  = out_valid_q && out_ready;

  // State register and all datapath/output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rf_addr_q   <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rf_addr_q   <= rf_addr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state_q;
    rf_addr_d   = rf_addr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          rf_addr_d = ADDR_W'(FIRST_REG);
          busy_d    = 1'b1;
          state_d   = READ;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end

      READ: begin
        out_data_d  = rf_data;
        out_addr_d  = rf_addr_q;
        out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = at_last_c;
`endif
        state_d     = HOLD;
      end

      HOLD: begin
        if (accept_c) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d      = csum_q ^ out_data_q;
`endif
          if (at_last_c) begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum beat goes out immediately, including the beat just accepted.
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            out_addr_d  = '0;
            out_data_d  = csum_q ^ out_data_q;
            state_d     = CSUM;
`else
            state_d     = DONE;
`endif
          end else begin
            rf_addr_d = rf_addr_q + ADDR_W'(1);
            state_d   = READ;
          end
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (accept_c) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = DONE;
        end
      end
`endif

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rf_addr   = rf_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule : reg_dump_reader

// File: tb/tb_reg_dump_reader.sv
// Directed self-checking bench for reg_dump_reader: full dump, backpressure, start while busy,
// mid-dump reset and a single-register dump; expectations follow REG_DUMP_CHECKSUM_EN.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start1;
  logic        out_ready, out_ready1;
  logic        busy, done, out_valid, out_last;
  logic        busy1, done1, out_valid1, out_last1;
  logic [4:0]  rf_addr, out_addr, rf_addr1, out_addr1;
  logic [31:0] rf_data, out_data, rf_data1, out_data1;
  logic [31:0] rf [32];

  int errors = 0;
  int checks = 0;

  assign rf_data  = rf[rf_addr];
  assign rf_data1 = rf[rf_addr1];

  always #5 clk = ~clk;

  reg_dump_reader dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
  );

  reg_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .rf_addr(rf_addr1), .rf_data(rf_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_addr(out_addr1), .out_data(out_data1), .out_last(out_last1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete dump of x1..x31; optional stall on one beat and start pokes while busy.
  task automatic dump(input int stall_addr, input int stall_len, input bit poke_start);
    int          waited;
    logic [31:0] acc;
    acc = 32'h0;
    for (int a = 1; a <= 31; a++) begin
      waited = 0;
      while (out_valid !== 1'b1 && waited < 8) begin
        tick();
        waited++;
      end
      chk("beat_valid", {31'b0, out_valid}, 32'd1);
      chk("beat_addr", {27'b0, out_addr}, 32'(a));
      chk("beat_data", out_data, 32'h1000_0000 + 32'(a));
`ifdef REG_DUMP_CHECKSUM_EN
      chk("beat_last", {31'b0, out_last}, 32'd0);
`else
      chk("beat_last", {31'b0, out_last}, (a == 31) ? 32'd1 : 32'd0);
`endif
      acc = acc ^ (32'h1000_0000 + 32'(a));
      if (poke_start && a == 10) start = 1'b1;
      if (a == stall_addr) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          start = 1'b0;
          chk("stall_valid", {31'b0, out_valid}, 32'd1);
          chk("stall_addr", {27'b0, out_addr}, 32'(a));
          chk("stall_data", out_data, 32'h1000_0000 + 32'(a));
        end
        out_ready = 1'b1;
      end
      tick();
      start = 1'b0;
    end
`ifdef REG_DUMP_CHECKSUM_EN
    chk("csum_valid", {31'b0, out_valid}, 32'd1);
    chk("csum_addr", {27'b0, out_addr}, 32'd0);
    chk("csum_data", out_data, acc);
    chk("csum_last", {31'b0, out_last}, 32'd1);
    tick();
`endif
    // DONE cycle: one cycle after the final acceptance
    chk("done_cyc_valid", {31'b0, out_valid}, 32'd0);
    chk("done_cyc_done", {31'b0, done}, 32'd0);
    chk("done_cyc_busy", {31'b0, busy}, 32'd1);
    if (poke_start) start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_fall", {31'b0, busy}, 32'd0);
    tick();
    chk("done_once", {31'b0, done}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("idle_valid", {31'b0, out_valid}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    reset      = 1'b1;
    start      = 1'b0;
    start1     = 1'b0;
    out_ready  = 1'b1;
    out_ready1 = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_rf_addr", {27'b0, rf_addr}, 32'd0);
    chk("rst_out_addr", {27'b0, out_addr}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    tick();

    // Full-rate dump with latency checks
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat1_busy", {31'b0, busy}, 32'd1);
    chk("lat1_valid", {31'b0, out_valid}, 32'd0);
    chk("lat1_rf_addr", {27'b0, rf_addr}, 32'd1);
    tick();
    chk("lat2_valid", {31'b0, out_valid}, 32'd1);
    dump(0, 0, 1'b0);

    // Backpressure on addr 7
    start = 1'b1;
    tick();
    start = 1'b0;
    dump(7, 5, 1'b0);

    // start pulses while busy are ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    dump(0, 0, 1'b1);

    // Reset during HOLD of addr 15
    start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (!(out_valid === 1'b1 && out_addr === 5'd15) && waited < 100) begin
      tick();
      waited++;
    end
    chk("reach_addr15", {27'b0, out_addr}, 32'd15);
    out_ready = 1'b0;
    tick();
    chk("hold15_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_rf_addr", {27'b0, rf_addr}, 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    dump(0, 0, 1'b0);

    // Single-register dump FIRST_REG == LAST_REG == 5
    rf[5] = 32'hDEAD_BEEF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("one_busy", {31'b0, busy1}, 32'd1);
    tick();
    chk("one_valid", {31'b0, out_valid1}, 32'd1);
    chk("one_addr", {27'b0, out_addr1}, 32'd5);
    chk("one_data", out_data1, 32'hDEAD_BEEF);
`ifdef REG_DUMP_CHECKSUM_EN
    chk("one_last", {31'b0, out_last1}, 32'd0);
    tick();
    chk("one_csum_addr", {27'b0, out_addr1}, 32'd0);
    chk("one_csum_data", out_data1, 32'hDEAD_BEEF);
    chk("one_csum_last", {31'b0, out_last1}, 32'd1);
`else
    chk("one_last", {31'b0, out_last1}, 32'd1);
`endif
    tick();
    chk("one_after_valid", {31'b0, out_valid1}, 32'd0);
    tick();
    chk("one_done", {31'b0, done1}, 32'd1);
    chk("one_busy_fall", {31'b0, busy1}, 32'd0);
    tick();
    chk("one_idle_valid", {31'b0, out_valid1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_dump_reader
